ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand front end for the execute stage. Captures a decoded instruction from the decode stage and registers it. Each cycle it produces the ALU operands `alu_a`/`alu_b` (with EX/MEM and MEM/WB forwarding) and the 4-bit `alu_control` code for the ALU. It also detects load-use hazards and handles pipeline stall/flush.

---
 rtl/ex_operand_stage.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with ALU-control decode, EX-stage operand forwarding
// and load-use hazard detection for a 32-bit RISC-V style integer pipeline.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic            id_f7b5,
  input  logic            id_f7b0,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_reg_write,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_is_load,
  output logic            ex_is_store,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MUL  = 4'b1010;

  localparam logic [XLEN-1:0] CONST_FOUR = XLEN'(4);

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_t;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_t;

  // ---------------- decode (combinational on id_*) ----------------
  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic       dec_writes;
  logic       dec_reg_write;
  logic       dec_is_load;
  logic       dec_is_store;
  a_sel_t     dec_a_sel;
  b_sel_t     dec_b_sel;
  logic       uses_rs1;
  logic       uses_rs2;
  logic [3:0] f3_alu;

  // Shared funct3 map for R-type and OP-IMM; only R-type may turn 000 into SUB.
  always_comb begin
    f3_alu = ALU_ADD;
    case (id_funct3)
      3'b000:  f3_alu = (id_opcode == OP_R && id_f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = id_f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  end

  always_comb begin
    dec_alu      = ALU_ADD;
    dec_illegal  = 1'b0;
    dec_writes   = 1'b0;
    dec_is_load  = 1'b0;
    dec_is_store = 1'b0;
    dec_a_sel    = A_RS1;
    dec_b_sel    = B_RS2;
    uses_rs1     = 1'b1;
    uses_rs2     = 1'b0;
    case (id_opcode)
      OP_R: begin
        dec_writes = 1'b1;
        uses_rs2   = 1'b1;
        if (id_f7b0) begin
          if (id_funct3 == 3'b000) dec_alu = ALU_MUL;
          else                     dec_illegal = 1'b1;
        end else begin
          dec_alu = f3_alu;
        end
      end
      OP_IMM: begin
        dec_writes = 1'b1;
        dec_b_sel  = B_IMM;
        dec_alu    = f3_alu;
      end
      OP_LOAD: begin
        dec_writes  = 1'b1;
        dec_is_load = 1'b1;
        dec_b_sel   = B_IMM;
      end
      OP_STORE: begin
        dec_is_store = 1'b1;
        uses_rs2     = 1'b1;
        dec_b_sel    = B_IMM;
      end
      OP_LUI: begin
        dec_writes = 1'b1;
        uses_rs1   = 1'b0;
        dec_a_sel  = A_ZERO;
        dec_b_sel  = B_IMM;
      end
      OP_AUIPC: begin
        dec_writes = 1'b1;
        uses_rs1   = 1'b0;
        dec_a_sel  = A_PC;
        dec_b_sel  = B_IMM;
      end
      OP_JAL: begin
        dec_writes = 1'b1;
        uses_rs1   = 1'b0;
        dec_a_sel  = A_PC;
        dec_b_sel  = B_FOUR;
      end
      OP_JALR: begin
        dec_writes = 1'b1;
        dec_a_sel  = A_PC;
        dec_b_sel  = B_FOUR;
      end
      OP_BRANCH: begin
        uses_rs2 = 1'b1;
        dec_alu  = ALU_SUB;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_alu    = ALU_ADD;
      dec_writes = 1'b0;
    end
    dec_reg_write = dec_writes && (id_rd != 5'd0);
  end

  // ---------------- ID/EX register ----------------
  logic            ex_valid_reg;
  logic [XLEN-1:0] ex_pc_reg;
  logic [XLEN-1:0] ex_rs1_data_reg;
  logic [XLEN-1:0] ex_rs2_data_reg;
  logic [XLEN-1:0] ex_imm_reg;
  logic [4:0]      ex_rs1_reg;
  logic [4:0]      ex_rs2_reg;
  logic [4:0]      ex_rd_reg;
  logic [3:0]      ex_alu_reg;
  logic            ex_reg_write_reg;
  logic            ex_is_load_reg;
  logic            ex_is_store_reg;
  logic            ex_illegal_reg;
  a_sel_t          ex_a_sel_reg;
  b_sel_t          ex_b_sel_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg     <= 1'b0;
      ex_pc_reg        <= '0;
      ex_rs1_data_reg  <= '0;
      ex_rs2_data_reg  <= '0;
      ex_imm_reg       <= '0;
      ex_rs1_reg       <= '0;
      ex_rs2_reg       <= '0;
      ex_rd_reg        <= '0;
      ex_alu_reg       <= ALU_ADD;
      ex_reg_write_reg <= 1'b0;
      ex_is_load_reg   <= 1'b0;
      ex_is_store_reg  <= 1'b0;
      ex_illegal_reg   <= 1'b0;
      ex_a_sel_reg     <= A_RS1;
      ex_b_sel_reg     <= B_RS2;
    end else if (flush || (!stall && load_use_stall)) begin
      // Bubble: only the control bits matter, datapath fields are left as-is.
      ex_valid_reg     <= 1'b0;
      ex_reg_write_reg <= 1'b0;
      ex_is_load_reg   <= 1'b0;
      ex_is_store_reg  <= 1'b0;
      ex_illegal_reg   <= 1'b0;
    end else if (!stall) begin
      ex_valid_reg     <= id_valid;
      ex_pc_reg        <= id_pc;
      ex_rs1_data_reg  <= id_rs1_data;
      ex_rs2_data_reg  <= id_rs2_data;
      ex_imm_reg       <= id_imm;
      ex_rs1_reg       <= id_rs1;
      ex_rs2_reg       <= id_rs2;
      ex_rd_reg        <= id_rd;
      ex_alu_reg       <= id_valid ? dec_alu : ALU_ADD;
      ex_reg_write_reg <= id_valid && dec_reg_write;
      ex_is_load_reg   <= id_valid && dec_is_load;
      ex_is_store_reg  <= id_valid && dec_is_store;
      ex_illegal_reg   <= id_valid && dec_illegal;
      ex_a_sel_reg     <= dec_a_sel;
      ex_b_sel_reg     <= dec_b_sel;
    end
  end

  // ---------------- forwarding (index 0 = rs1, 1 = rs2) ----------------
  logic [4:0]      src_addr [2];
  logic [XLEN-1:0] src_data [2];
  logic [XLEN-1:0] fwd_data [2];

  assign src_addr[0] = ex_rs1_reg;
  assign src_addr[1] = ex_rs2_reg;
  assign src_data[0] = ex_rs1_data_reg;
  assign src_data[1] = ex_rs2_data_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit;
      logic wb_hit;
      assign mem_hit = mem_reg_write && (mem_rd == src_addr[gi]) && (src_addr[gi] != 5'd0);
      assign wb_hit  = wb_reg_write && (wb_rd == src_addr[gi]) && (src_addr[gi] != 5'd0);
      assign fwd_data[gi] = mem_hit ? mem_result : (wb_hit ? wb_result : src_data[gi]);
    end
  endgenerate

  always_comb begin
    alu_a = fwd_data[0];
    case (ex_a_sel_reg)
      A_PC:    alu_a = ex_pc_reg;
      A_ZERO:  alu_a = '0;
      default: alu_a = fwd_data[0];
    endcase
  end

  always_comb begin
    alu_b = fwd_data[1];
    case (ex_b_sel_reg)
      B_IMM:   alu_b = ex_imm_reg;
      B_FOUR:  alu_b = CONST_FOUR;
      default: alu_b = fwd_data[1];
    endcase
  end

  // ---------------- load-use hazard ----------------
  assign load_use_stall = ex_valid_reg && ex_is_load_reg && (ex_rd_reg != 5'd0) && id_valid &&
                          ((uses_rs1 && (id_rs1 == ex_rd_reg)) ||
                           (uses_rs2 && (id_rs2 == ex_rd_reg)));

  assign ex_valid      = ex_valid_reg;
  assign alu_control   = ex_alu_reg;
  assign ex_store_data = fwd_data[1];
  assign ex_rd         = ex_rd_reg;
  assign ex_reg_write  = ex_reg_write_reg;
  assign ex_is_load    = ex_is_load_reg;
  assign ex_is_store   = ex_is_store_reg;
  assign ex_pc         = ex_pc_reg;
  assign ex_illegal    = ex_illegal_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed-vector bench for ex_operand_stage: decode table, forwarding priority,
// load-use hazard, stall/flush and asynchronous reset.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic        id_f7b5, id_f7b0;
  logic        stall, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_is_load, ex_is_store, ex_illegal;

  int total = 0;
  int bad = 0;

  ex_operand_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_f7b5(id_f7b5), .id_f7b0(id_f7b0),
    .stall(stall), .flush(flush), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_result(mem_result), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_result(wb_result), .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_is_load(ex_is_load), .ex_is_store(ex_is_store), .ex_pc(ex_pc),
    .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("pass %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic b5,
                         input logic b0, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc);
    id_valid = 1'b1; id_opcode = op; id_funct3 = f3; id_f7b5 = b5; id_f7b0 = b0;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       b5;
    logic       b0;
    logic [4:0] rd;
    logic [3:0] ctl;
    logic       rw;
    logic       ill;
    logic       ld;
    logic       st;
    logic       chk_ops;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{"srai",   7'b0010011, 3'b101, 1'b1, 1'b0, 5'd3, 4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h10};
    vecs[1]  = '{"addi",   7'b0010011, 3'b000, 1'b1, 1'b0, 5'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h10};
    vecs[2]  = '{"sltu",   7'b0110011, 3'b011, 1'b0, 1'b0, 5'd3, 4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h55};
    vecs[3]  = '{"srl",    7'b0110011, 3'b101, 1'b0, 1'b0, 5'd3, 4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h55};
    vecs[4]  = '{"mul",    7'b0110011, 3'b000, 1'b0, 1'b1, 5'd3, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h55};
    vecs[5]  = '{"ill_m",  7'b0110011, 3'b001, 1'b0, 1'b1, 5'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[6]  = '{"auipc",  7'b0010111, 3'b000, 1'b0, 1'b0, 5'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h10};
    vecs[7]  = '{"jal",    7'b1101111, 3'b000, 1'b0, 1'b0, 5'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h4};
    vecs[8]  = '{"jalr",   7'b1100111, 3'b000, 1'b0, 1'b0, 5'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2000, 32'h4};
    vecs[9]  = '{"lui",    7'b0110111, 3'b000, 1'b0, 1'b0, 5'd3, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    32'h10};
    vecs[10] = '{"branch", 7'b1100011, 3'b001, 1'b0, 1'b0, 5'd3, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h55};
    vecs[11] = '{"store",  7'b0100011, 3'b010, 1'b0, 1'b0, 5'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h100,  32'h10};
    vecs[12] = '{"add_x0", 7'b0110011, 3'b000, 1'b0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100,  32'h55};
    vecs[13] = '{"ill_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 5'd3, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    32'h0};
    vecs[14] = '{"load",   7'b0000011, 3'b010, 1'b0, 1'b0, 5'd3, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100,  32'h10};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    mem_reg_write = 1'b0; mem_rd = '0; mem_result = '0;
    wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
    present(7'b0110011, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    id_valid = 1'b0;

    // reset state
    #1;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_ctl", {28'd0, alu_control}, 32'd0);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    check("rst_pc", ex_pc, 32'd0);
    check("rst_ill", {31'd0, ex_illegal}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // SUB decode
    present(7'b0110011, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'd100, 32'd30, 32'h0, 32'h40);
    step();
    check("sub_ctl", {28'd0, alu_control}, 32'd1);
    check("sub_a", alu_a, 32'd100);
    check("sub_b", alu_b, 32'd30);
    check("sub_rw", {31'd0, ex_reg_write}, 32'd1);
    check("sub_valid", {31'd0, ex_valid}, 32'd1);
    check("sub_pc", ex_pc, 32'h40);

    // forwarding priority
    present(7'b0110011, 3'b000, 1'b0, 1'b0, 5'd5, 5'd6, 5'd9, 32'h11, 32'h22, 32'h0, 32'h44);
    step();
    mem_reg_write = 1'b1; mem_rd = 5'd5; mem_result = 32'hAAAA;
    wb_reg_write = 1'b1; wb_rd = 5'd5; wb_result = 32'hBBBB;
    #1;
    check("fwd_mem", alu_a, 32'hAAAA);
    check("fwd_b_none", alu_b, 32'h22);
    mem_reg_write = 1'b0;
    #1;
    check("fwd_wb", alu_a, 32'hBBBB);
    wb_reg_write = 1'b0;
    #1;
    check("fwd_rf", alu_a, 32'h11);
    wb_reg_write = 1'b1; wb_rd = 5'd6;
    #1;
    check("fwd_wb_b", alu_b, 32'hBBBB);
    check("fwd_store", ex_store_data, 32'hBBBB);
    wb_reg_write = 1'b0;

    // x0 never forwarded
    present(7'b0110011, 3'b000, 1'b0, 1'b0, 5'd1, 5'd0, 5'd4, 32'h7, 32'h0, 32'h0, 32'h48);
    step();
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'hDEAD;
    wb_reg_write = 1'b1; wb_rd = 5'd0; wb_result = 32'hBEEF;
    #1;
    check("x0_b", alu_b, 32'h0);
    mem_reg_write = 1'b0; wb_reg_write = 1'b0; mem_rd = '0; wb_rd = '0;

    // decode table
    for (int i = 0; i < 15; i++) begin
      present(vecs[i].op, vecs[i].f3, vecs[i].b5, vecs[i].b0, 5'd1, 5'd2, vecs[i].rd,
              32'h100, 32'h55, 32'h10, 32'h2000);
      step();
      check({vecs[i].name, "_ctl"}, {28'd0, alu_control}, {28'd0, vecs[i].ctl});
      check({vecs[i].name, "_rw"}, {31'd0, ex_reg_write}, {31'd0, vecs[i].rw});
      check({vecs[i].name, "_ill"}, {31'd0, ex_illegal}, {31'd0, vecs[i].ill});
      check({vecs[i].name, "_ld"}, {31'd0, ex_is_load}, {31'd0, vecs[i].ld});
      check({vecs[i].name, "_st"}, {31'd0, ex_is_store}, {31'd0, vecs[i].st});
      if (vecs[i].chk_ops) begin
        check({vecs[i].name, "_a"}, alu_a, vecs[i].a);
        check({vecs[i].name, "_b"}, alu_b, vecs[i].b);
      end
    end

    // load-use via rs1
    present(7'b0000011, 3'b010, 1'b0, 1'b0, 5'd2, 5'd0, 5'd7, 32'h300, 32'h0, 32'h8, 32'h50);
    step();
    present(7'b0110011, 3'b000, 1'b0, 1'b0, 5'd7, 5'd1, 5'd8, 32'h1, 32'h2, 32'h0, 32'h54);
    #1;
    check("lu_stall", {31'd0, load_use_stall}, 32'd1);
    step();
    check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_clear", {31'd0, load_use_stall}, 32'd0);
    step();
    check("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_cap_rd", {27'd0, ex_rd}, 32'd8);
    check("lu_cap_pc", ex_pc, 32'h54);

    // load-use via rs2; LUI ignores its rs1 field
    present(7'b0000011, 3'b010, 1'b0, 1'b0, 5'd2, 5'd0, 5'd7, 32'h300, 32'h0, 32'h8, 32'h58);
    step();
    present(7'b0110011, 3'b000, 1'b1, 1'b0, 5'd1, 5'd7, 5'd9, 32'h1, 32'h2, 32'h0, 32'h5C);
    #1;
    check("lu_rs2", {31'd0, load_use_stall}, 32'd1);
    present(7'b0110111, 3'b000, 1'b0, 1'b0, 5'd7, 5'd7, 5'd9, 32'h1, 32'h2, 32'h1000, 32'h5C);
    #1;
    check("lu_lui", {31'd0, load_use_stall}, 32'd0);

    // stall holds for three cycles
    present(7'b0110011, 3'b100, 1'b0, 1'b0, 5'd1, 5'd2, 5'd10, 32'h5, 32'h3, 32'h0, 32'h60);
    step();
    check("xor_ctl", {28'd0, alu_control}, 32'd4);
    stall = 1'b1;
    present(7'b0110011, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2, 5'd11, 32'h9, 32'h9, 32'h0, 32'h64);
    step(); step(); step();
    check("stall_ctl", {28'd0, alu_control}, 32'd4);
    check("stall_rd", {27'd0, ex_rd}, 32'd10);
    check("stall_a", alu_a, 32'h5);
    check("stall_pc", ex_pc, 32'h60);
    flush = 1'b1;
    step();
    check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    flush = 1'b0; stall = 1'b0;

    // invalid capture clears control
    id_valid = 1'b0;
    step();
    check("inv_valid", {31'd0, ex_valid}, 32'd0);
    check("inv_rw", {31'd0, ex_reg_write}, 32'd0);

    // asynchronous reset between edges
    present(7'b0110011, 3'b000, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 32'h9, 32'h4, 32'h0, 32'h70);
    step();
    check("pre_rst_ctl", {28'd0, alu_control}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_ctl", {28'd0, alu_control}, 32'd0);
    check("arst_pc", ex_pc, 32'd0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
